maze_move_tracker: RTL and testbench

Downstream consumer of the maze explorer's `move` command stream. It keeps an independent pose model (cell index and heading) on the 9x9 grid and reports dead-end U-turns, step count, exit arrival and illegal commands. It also records every executed move in a readback log for later path replay and shortest-path extraction. It sits between the explorer and the bench/replay logic and is the design's ground-truth position checker.

---
 rtl/maze_pkg.sv | 91 +++++++++
 rtl/maze_move_tracker_log.sv | 64 ++++++
 rtl/maze_move_tracker.sv | 131 +++++++++++++
 tb/tb_maze_move_tracker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze tracker: move codes, headings, FSM states
// and the pose helper functions used by maze_move_tracker.
package maze_pkg;

    localparam int GRID_N_DEFAULT = 9;

    localparam logic [2:0] MOVE_STOP    = 3'd0;
    localparam logic [2:0] MOVE_FORWARD = 3'd1;
    localparam logic [2:0] MOVE_LEFT    = 3'd2;
    localparam logic [2:0] MOVE_RIGHT   = 3'd3;
    localparam logic [2:0] MOVE_U_TURN  = 3'd4;

    typedef enum logic [1:0] {
        HEAD_N = 2'd0,
        HEAD_S = 2'd1,
        HEAD_E = 2'd2,
        HEAD_W = 2'd3
    } heading_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    // LEFT walks N -> W -> S -> E -> N
    function automatic heading_t turn_left(input heading_t h);
        heading_t r;
        case (h)
            HEAD_N:  r = HEAD_W;
            HEAD_W:  r = HEAD_S;
            HEAD_S:  r = HEAD_E;
            default: r = HEAD_N;
        endcase
        return r;
    endfunction

    // RIGHT walks N -> E -> S -> W -> N
    function automatic heading_t turn_right(input heading_t h);
        heading_t r;
        case (h)
            HEAD_N:  r = HEAD_E;
            HEAD_E:  r = HEAD_S;
            HEAD_S:  r = HEAD_W;
            default: r = HEAD_N;
        endcase
        return r;
    endfunction

    function automatic heading_t reverse(input heading_t h);
        heading_t r;
        case (h)
            HEAD_N:  r = HEAD_S;
            HEAD_S:  r = HEAD_N;
            HEAD_E:  r = HEAD_W;
            default: r = HEAD_E;
        endcase
        return r;
    endfunction

    // True when a single step from idx along h stays inside the grid
    function automatic logic on_grid(input logic [6:0] idx, input heading_t h, input int grid_n);
        int   row;
        int   col;
        logic ok;
        row = int'(idx) / grid_n;
        col = int'(idx) % grid_n;
        case (h)
            HEAD_N:  ok = (row != 0);
            HEAD_S:  ok = (row != grid_n - 1);
            HEAD_E:  ok = (col != grid_n - 1);
            default: ok = (col != 0);
        endcase
        return ok;
    endfunction

    // Cell index after one step along h (caller guarantees the step is on-grid)
    function automatic logic [6:0] step_index(input logic [6:0] idx, input heading_t h, input int grid_n);
        logic [6:0] row_step;
        logic [6:0] r;
        row_step = 7'(grid_n);
        case (h)
            HEAD_N:  r = idx - row_step;
            HEAD_S:  r = idx + row_step;
            HEAD_E:  r = idx + 7'd1;
            default: r = idx - 7'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/maze_move_tracker_log.sv
// move_log_fifo: small wrapping-pointer FIFO holding executed move codes.
// Only instantiated by maze_move_tracker when TRACKER_LOG_EN is defined.
// A write into a full FIFO is dropped (sticky overflow) unless a read in the
// same cycle frees a slot; a read from an empty FIFO is ignored.
module move_log_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_rd;
    logic             do_wr;

    assign do_rd = rd_en && (count != '0);
    assign do_wr = wr_en && ((count != FULL_CNT) || do_rd);
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers, occupancy, read data register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full && !rd_en) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/maze_move_tracker.sv
// maze_move_tracker: independent pose model of the maze explorer on a
// GRID_N x GRID_N grid. Tracks cell/heading, counts steps and U-turns,
// flags exit arrival and illegal commands.
// Optional macro TRACKER_LOG_EN compiles in the move_log_fifo readback log;
// without it the log ports are tied to their idle values.
module maze_move_tracker
    import maze_pkg::*;
#(
    parameter int GRID_N    = GRID_N_DEFAULT,
    parameter int START_IDX = 76,
    parameter int EXIT_IDX  = 4,
    parameter int LOG_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_valid,
    input  logic [2:0] move,
    output logic [6:0] cur_idx,
    output logic [1:0] heading,
    output logic [7:0] step_cnt,
    output logic [3:0] deadend_cnt,
    output logic       exit_reached,
    output logic       err,
    input  logic       log_rd_en,
    output logic [2:0] log_rd_data,
    output logic       log_empty,
    output logic       log_full,
    output logic       log_overflow
);

    localparam logic [6:0] START_CELL = 7'(START_IDX);
    localparam logic [6:0] EXIT_CELL  = 7'(EXIT_IDX);

    state_t     state;
    state_t     state_next;
    heading_t   head_q;
    heading_t   move_head;
    logic [6:0] idx_next;
    logic       is_step;
    logic       bad_code;
    logic       exec_move;
    logic       enter_error;

    assign heading = head_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    // Decode the command, resolve the target cell and choose the next state
    always_comb begin
        state_next  = state;
        move_head   = head_q;
        idx_next    = cur_idx;
        is_step     = 1'b0;
        bad_code    = 1'b0;
        exec_move   = 1'b0;
        enter_error = 1'b0;
        if (state == ST_RUN && move_valid) begin
            case (move)
                MOVE_STOP:    is_step = 1'b0;
                MOVE_FORWARD: is_step = 1'b1;
                MOVE_LEFT:    begin is_step = 1'b1; move_head = turn_left(head_q);  end
                MOVE_RIGHT:   begin is_step = 1'b1; move_head = turn_right(head_q); end
                MOVE_U_TURN:  begin is_step = 1'b1; move_head = reverse(head_q);    end
                default:      bad_code = 1'b1;
            endcase
            if (bad_code) begin
                state_next  = ST_ERROR;
                enter_error = 1'b1;
            end else if (is_step) begin
                if (on_grid(cur_idx, move_head, GRID_N)) begin
                    exec_move = 1'b1;
                    idx_next  = step_index(cur_idx, move_head, GRID_N);
                    if (idx_next == EXIT_CELL) state_next = ST_DONE;
                end else begin
                    state_next  = ST_ERROR;
                    enter_error = 1'b1;
                end
            end
        end
    end

    // Pose, saturating counters and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_idx      <= START_CELL;
            head_q       <= HEAD_N;
            step_cnt     <= '0;
            deadend_cnt  <= '0;
            exit_reached <= 1'b0;
            err          <= 1'b0;
        end else begin
            if (exec_move) begin
                cur_idx <= idx_next;
                head_q  <= move_head;
                if (step_cnt != 8'hFF) step_cnt <= step_cnt + 8'd1;
                if (move == MOVE_U_TURN && deadend_cnt != 4'hF) deadend_cnt <= deadend_cnt + 4'd1;
                if (idx_next == EXIT_CELL) exit_reached <= 1'b1;
            end
            if (enter_error) err <= 1'b1;
        end
    end

`ifdef TRACKER_LOG_EN
    move_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (3)
    ) u_log (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (exec_move),
        .wr_data  (move),
        .rd_en    (log_rd_en),
        .rd_data  (log_rd_data),
        .empty    (log_empty),
        .full     (log_full),
        .overflow (log_overflow)
    );
`else
    logic log_unused;
    assign log_unused   = log_rd_en & (LOG_DEPTH > 0);
    assign log_rd_data  = 3'd0;
    assign log_empty    = 1'b1;
    assign log_full     = 1'b0;
    assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_maze_move_tracker.sv
// Self-checking bench for maze_move_tracker: a grid-walk reference model
// predicts each cycle's outputs into a scoreboard queue; a monitor pops and
// compares whenever a move or log read is presented. Log expectations follow
// TRACKER_LOG_EN.
module tb_maze_move_tracker;

    localparam int GRID_N    = 9;
    localparam int START_IDX = 76;
    localparam int EXIT_IDX  = 4;
    localparam int LOG_DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_valid = 1'b0;
    logic [2:0] move = 3'd0;
    logic       log_rd_en = 1'b0;
    logic [6:0] cur_idx;
    logic [1:0] heading;
    logic [7:0] step_cnt;
    logic [3:0] deadend_cnt;
    logic       exit_reached;
    logic       err;
    logic [2:0] log_rd_data;
    logic       log_empty;
    logic       log_full;
    logic       log_overflow;

    maze_move_tracker #(
        .GRID_N    (GRID_N),
        .START_IDX (START_IDX),
        .EXIT_IDX  (EXIT_IDX),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .move_valid   (move_valid),
        .move         (move),
        .cur_idx      (cur_idx),
        .heading      (heading),
        .step_cnt     (step_cnt),
        .deadend_cnt  (deadend_cnt),
        .exit_reached (exit_reached),
        .err          (err),
        .log_rd_en    (log_rd_en),
        .log_rd_data  (log_rd_data),
        .log_empty    (log_empty),
        .log_full     (log_full),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int head;
        int steps;
        int dead;
        int ext;
        int er;
        int emp;
        int ful;
        int ovf;
        int rdd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: row/col and a compass angle (0=N,1=E,2=S,3=W clockwise)
    int m_row, m_col, m_ang;
    bit m_done, m_err, m_exit, m_ovf;
    int m_steps, m_dead, m_rdd;
    int m_log[$];

    function automatic int angToCode(input int a);
        case (a)
            0:       return 0;
            1:       return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic void modelReset();
        m_row = START_IDX / GRID_N;
        m_col = START_IDX % GRID_N;
        m_ang = 0;
        m_done = 0; m_err = 0; m_exit = 0; m_ovf = 0;
        m_steps = 0; m_dead = 0; m_rdd = 0;
        m_log.delete();
    endfunction

    function automatic exp_t snapshot();
        exp_t s;
        s.idx   = m_row * GRID_N + m_col;
        s.head  = angToCode(m_ang);
        s.steps = m_steps;
        s.dead  = m_dead;
        s.ext   = int'(m_exit);
        s.er    = int'(m_err);
        s.emp   = (m_log.size() == 0) ? 1 : 0;
        s.ful   = (m_log.size() == LOG_DEPTH) ? 1 : 0;
        s.ovf   = int'(m_ovf);
        s.rdd   = m_rdd;
        return s;
    endfunction

    function automatic void modelStep(input bit mv_v, input int code, input bit rd);
        bit exec;
        int a, nr, nc;
        exec = 0;
        if (mv_v && !m_done && !m_err) begin
            if (code >= 5) begin
                m_err = 1;
            end else if (code != 0) begin
                a = m_ang;
                if (code == 2) a = (a + 3) % 4;
                if (code == 3) a = (a + 1) % 4;
                if (code == 4) a = (a + 2) % 4;
                nr = m_row; nc = m_col;
                case (a)
                    0:       nr = nr - 1;
                    1:       nc = nc + 1;
                    2:       nr = nr + 1;
                    default: nc = nc - 1;
                endcase
                if (nr < 0 || nr >= GRID_N || nc < 0 || nc >= GRID_N) begin
                    m_err = 1;
                end else begin
                    m_row = nr; m_col = nc; m_ang = a;
                    exec = 1;
                    if (m_steps < 255) m_steps++;
                    if (code == 4 && m_dead < 15) m_dead++;
                    if (nr * GRID_N + nc == EXIT_IDX) begin
                        m_done = 1;
                        m_exit = 1;
                    end
                end
            end
        end
`ifdef TRACKER_LOG_EN
        if (rd && m_log.size() > 0) m_rdd = m_log.pop_front();
        if (exec) begin
            if (m_log.size() < LOG_DEPTH) m_log.push_back(code);
            else m_ovf = 1;
        end
`else
        if (rd || exec) m_rdd = 0;
`endif
    endfunction

    task automatic checkField(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        checkField({tag, ".cur_idx"},      int'(cur_idx),      e.idx);
        checkField({tag, ".heading"},      int'(heading),      e.head);
        checkField({tag, ".step_cnt"},     int'(step_cnt),     e.steps);
        checkField({tag, ".deadend_cnt"},  int'(deadend_cnt),  e.dead);
        checkField({tag, ".exit_reached"}, int'(exit_reached), e.ext);
        checkField({tag, ".err"},          int'(err),          e.er);
        checkField({tag, ".log_empty"},    int'(log_empty),    e.emp);
        checkField({tag, ".log_full"},     int'(log_full),     e.ful);
        checkField({tag, ".log_overflow"}, int'(log_overflow), e.ovf);
        checkField({tag, ".log_rd_data"},  int'(log_rd_data),  e.rdd);
    endtask

    // Drive one cycle of stimulus on the falling edge and queue its prediction
    task automatic applyStimulus(input bit mv_v, input logic [2:0] code, input bit rd);
        @(negedge clk);
        move_valid = mv_v;
        move       = code;
        log_rd_en  = rd;
        modelStep(mv_v, int'(code), rd);
        if (mv_v || rd) exp_q.push_back(snapshot());
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; move_valid = 1'b0; move = 3'd0; log_rd_en = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        checkOutput(snapshot(), "reset");
        rst_n = 1'b1;
    endtask

    // Monitor: one prediction is consumed per cycle that presents a move or read
    always @(posedge clk) begin
        exp_t e;
        if (rst_n && (move_valid || log_rd_en)) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got empty queue required a prediction at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput(e, "cycle");
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] code;
        int r;
        bit mv_v, rd;

        modelReset();
        $display("[TB] forward x4 then drain log");
        doReset();
        repeat (4) applyStimulus(1, 3'd1, 0);
        repeat (5) applyStimulus(0, 3'd0, 1);

        $display("[TB] right, u_turn, left off the south edge");
        doReset();
        applyStimulus(1, 3'd3, 0);
        applyStimulus(1, 3'd4, 0);
        applyStimulus(1, 3'd2, 0);
        applyStimulus(1, 3'd1, 0);

        $display("[TB] forward x8 to the exit, then one ignored");
        doReset();
        repeat (9) applyStimulus(1, 3'd1, 0);
        applyStimulus(0, 3'd0, 1);

        $display("[TB] illegal code 6");
        doReset();
        applyStimulus(1, 3'd1, 0);
        applyStimulus(1, 3'd6, 0);
        applyStimulus(1, 3'd1, 0);
        applyStimulus(1, 3'd4, 0);

        $display("[TB] 70 moves into the log, overflow, full readback");
        doReset();
        applyStimulus(1, 3'd1, 0);
        repeat (69) applyStimulus(1, 3'd4, 0);
        repeat (65) applyStimulus(0, 3'd0, 1);

        $display("[TB] full log with simultaneous read and write");
        doReset();
        applyStimulus(1, 3'd1, 0);
        repeat (63) applyStimulus(1, 3'd4, 0);
        applyStimulus(1, 3'd4, 1);
        applyStimulus(1, 3'd4, 1);
        applyStimulus(1, 3'd4, 0);

        $display("[TB] randomized episodes");
        for (int ep = 0; ep < 20; ep++) begin
            doReset();
            for (int c = 0; c < 60; c++) begin
                r = int'($urandom_range(0, 63));
                if (r == 0)      code = 3'(5 + $urandom_range(0, 2));
                else if (r < 6)  code = 3'd0;
                else             code = 3'(1 + (r % 4));
                mv_v = ($urandom_range(0, 3) != 0);
                rd   = ($urandom_range(0, 3) == 0);
                applyStimulus(mv_v, code, rd);
            end
        end

        applyStimulus(0, 3'd0, 0);
        repeat (2) @(negedge clk);
        checkField("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
